fft_frame_ctrl: RTL

Frame sequencer for the FFT datapath on a single clock.
- Accepts a stream of complex samples over valid/ready and writes one N-point frame into the FFT core's working memory.
- Pulses the core start, waits for core done, then reads the N results back out as a valid/ready stream.
- Sits between the sample front-end and the FFT core; it owns all core control and addressing.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_skid_fifo.sv | 83 ++++++++
 rtl/fft_frame_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT frame sequencer.
// - state_e : sequencer states (sample load, core start, wait for core, result unload)
// - cplx_t  : one complex sample at the default component width
// - LOG2_N_DEF / DATA_W_DEF : default frame size exponent and component width
package fft_pkg;

  localparam int LOG2_N_DEF = 6;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } state_e;

  // "real" is a reserved word, hence re/im.
  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] re;
    logic signed [DATA_W_DEF-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_skid_fifo.sv
// Two-entry FIFO holding {last, re, im} words returned by the FFT core.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   push/push_data : write strobe and word (refused when full; the caller never does this)
//   pop            : remove the head word (ignored when empty)
//   occ            : number of stored words, 0..2
//   head           : oldest stored word, stable until popped
module fft_skid_fifo
  import fft_pkg::*;
#(
  parameter int W = 2 * DATA_W_DEF + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   occ_q, occ_d;

  // Next-state for the two storage slots; slot 0 is always the head.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          ent0_d = push_data;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          ent1_d = push_data;
          occ_d  = 2'd2;
        end else begin
          occ_d = occ_q;
        end
      end
      2'b01: begin
        if (occ_q != 2'd0) begin
          ent0_d = ent1_q;
          occ_d  = occ_q - 2'd1;
        end else begin
          occ_d = occ_q;
        end
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          ent0_d = ent1_q;
          ent1_d = push_data;
        end else begin
          // Empty or single entry: the pushed word becomes the head.
          ent0_d = push_data;
          occ_d  = 2'd1;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= {W{1'b0}};
      ent1_q <= {W{1'b0}};
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = ent0_q;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the FFT core: loads N input samples into core memory,
// pulses core_start, waits for core_done (bounded), then streams N results out.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   s_valid/s_ready/s_last/s_real/s_imag : input sample stream
//   core_wr_*                        : core memory write port (combinational from handshake)
//   core_start / core_done           : core control pulses
//   core_rd_en/core_rd_addr, core_rd_real/imag : core memory read port, 1-cycle latency
//   m_valid/m_ready/m_last/m_real/m_imag : output sample stream
//   err_short/err_long/err_timeout   : single-cycle registered error pulses
//   frame_cnt                        : completed output frames, wraps at 2**16
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2_N      = LOG2_N_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_last,
  input  logic signed [DATA_W-1:0] s_real,
  input  logic signed [DATA_W-1:0] s_imag,
  output logic                     core_wr_en,
  output logic [LOG2_N-1:0]        core_wr_addr,
  output logic signed [DATA_W-1:0] core_wr_real,
  output logic signed [DATA_W-1:0] core_wr_imag,
  output logic                     core_start,
  input  logic                     core_done,
  output logic                     core_rd_en,
  output logic [LOG2_N-1:0]        core_rd_addr,
  input  logic signed [DATA_W-1:0] core_rd_real,
  input  logic signed [DATA_W-1:0] core_rd_imag,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic signed [DATA_W-1:0] m_real,
  output logic signed [DATA_W-1:0] m_imag,
  output logic                     err_short,
  output logic                     err_long,
  output logic                     err_timeout,
  output logic [15:0]              frame_cnt
);

  localparam int                TCNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'((1 << LOG2_N) - 1);
  localparam logic [TCNT_W-1:0] TO_LAST  = TCNT_W'(TIMEOUT_CYC - 1);
  localparam int                FW       = 2 * DATA_W + 1;

  state_e              state_q, state_d;
  logic [LOG2_N-1:0]   widx_q, widx_d;
  // One extra bit: ridx == N means every read has been issued.
  logic [LOG2_N:0]     ridx_q, ridx_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                err_short_q, err_short_d;
  logic                err_long_q, err_long_d;
  logic                err_timeout_q, err_timeout_d;
  logic                inflight_q, inflight_last_q;

  logic                s_hs_s;
  logic                rd_en_s;
  logic                pop_s;
  logic [1:0]          fifo_occ_s;
  logic [FW-1:0]       head_s;
  logic [2:0]          fill_s;
  logic                space_s;

  // The sample port stays closed while reset is asserted so no write strobe escapes.
  assign s_ready      = rst_n & (state_q == LOAD);
  assign s_hs_s       = s_valid & s_ready;
  assign core_wr_en   = s_hs_s;
  assign core_wr_addr = widx_q;
  assign core_wr_real = s_real;
  assign core_wr_imag = s_imag;
  assign core_start   = (state_q == START);
  assign core_rd_en   = rd_en_s;
  assign core_rd_addr = ridx_q[LOG2_N-1:0];

  assign m_valid = (fifo_occ_s != 2'd0);
  assign m_last  = head_s[FW-1];
  assign m_real  = head_s[2*DATA_W-1:DATA_W];
  assign m_imag  = head_s[DATA_W-1:0];
  assign pop_s   = m_valid & m_ready;

  // Words stored plus the read still in flight, after this cycle's pop, must leave
  // room for one more so the FIFO can never overflow.
  assign fill_s  = {1'b0, fifo_occ_s} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign space_s = (fill_s < 3'd2);

  // Next-state and control decode for the frame sequencer.
  always_comb begin
    state_d       = state_q;
    widx_d        = widx_q;
    ridx_d        = ridx_q;
    tcnt_d        = tcnt_q;
    frame_cnt_d   = frame_cnt_q;
    err_short_d   = 1'b0;
    err_long_d    = 1'b0;
    err_timeout_d = 1'b0;
    rd_en_s       = 1'b0;
    case (state_q)
      LOAD: begin
        if (s_hs_s) begin
          if (widx_q == LAST_IDX) begin
            state_d    = START;
            widx_d     = {LOG2_N{1'b0}};
            err_long_d = ~s_last;
          end else if (s_last) begin
            err_short_d = 1'b1;
            widx_d      = {LOG2_N{1'b0}};
          end else begin
            widx_d = widx_q + LOG2_N'(1);
          end
        end else begin
          widx_d = widx_q;
        end
      end
      START: begin
        state_d = WAIT;
        tcnt_d  = {TCNT_W{1'b0}};
      end
      WAIT: begin
        if (core_done) begin
          state_d = UNLOAD;
          ridx_d  = {(LOG2_N + 1){1'b0}};
        end else if (tcnt_q == TO_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = LOAD;
          widx_d        = {LOG2_N{1'b0}};
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      UNLOAD: begin
        if (!ridx_q[LOG2_N] && space_s) begin
          rd_en_s = 1'b1;
          ridx_d  = ridx_q + (LOG2_N + 1)'(1);
        end else begin
          rd_en_s = 1'b0;
        end
        if (pop_s && m_last) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = LOAD;
          widx_d      = {LOG2_N{1'b0}};
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Sequencer state, indices, counters, error pulses and read-in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= LOAD;
      widx_q          <= {LOG2_N{1'b0}};
      ridx_q          <= {(LOG2_N + 1){1'b0}};
      tcnt_q          <= {TCNT_W{1'b0}};
      frame_cnt_q     <= 16'd0;
      err_short_q     <= 1'b0;
      err_long_q      <= 1'b0;
      err_timeout_q   <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      widx_q          <= widx_d;
      ridx_q          <= ridx_d;
      tcnt_q          <= tcnt_d;
      frame_cnt_q     <= frame_cnt_d;
      err_short_q     <= err_short_d;
      err_long_q      <= err_long_d;
      err_timeout_q   <= err_timeout_d;
      inflight_q      <= rd_en_s;
      inflight_last_q <= rd_en_s & (ridx_q[LOG2_N-1:0] == LAST_IDX);
    end
  end

  fft_skid_fifo #(
    .W(FW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data ({inflight_last_q, core_rd_real, core_rd_imag}),
    .pop       (pop_s),
    .occ       (fifo_occ_s),
    .head      (head_s)
  );

  assign err_short   = err_short_q;
  assign err_long    = err_long_q;
  assign err_timeout = err_timeout_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
